// File: rtl/topk_argmax.sv
`timescale 1ns/1ps
// topk_argmax: captures a vector of numOutputs scores on a start handshake,
// scans LANES scores per cycle and reports the best and second-best
// index/value pairs through a valid/ready result handshake.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   start / startReady   capture request; accepted when both are high (IDLE only)
//   dataIn               flat score vector, score i at [i*dataWidth +: dataWidth]
//   busy                 high while scanning
//   outValid / outReady  result handshake (DONE state)
//   maxIndex/maxValue    largest score and its lowest index
//   secondIndex/Value    best score among all other indices
//   margin               maxValue - secondValue, present only when the
//                        TOPK_MARGIN_EN macro is defined
//
// Ties resolve to the lowest index: lanes merge in ascending index order and a
// candidate only displaces a holder when strictly greater.
module topk_argmax #(
  parameter int dataWidth    = 8,
  parameter int numOutputs   = 10,
  parameter int LANES        = 2,
  parameter int SIGNED       = 0,
  parameter int addressWidth = $clog2(numOutputs)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  output logic                            startReady,
  input  logic [dataWidth*numOutputs-1:0] dataIn,
  output logic                            busy,
  output logic                            outValid,
  input  logic                            outReady,
  output logic [addressWidth-1:0]         maxIndex,
  output logic [dataWidth-1:0]            maxValue,
  output logic [addressWidth-1:0]         secondIndex,
  output logic [dataWidth-1:0]            secondValue
`ifdef TOPK_MARGIN_EN
  ,
  output logic [dataWidth:0]              margin
`endif
);

  localparam int NG = (numOutputs + LANES - 1) / LANES;
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;
  localparam int GV = LANES * dataWidth;
  localparam int PW = NG * GV;
  localparam int IW = $clog2(NG * LANES) + 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t state, nextState;

  logic [dataWidth*numOutputs-1:0] capture;
  logic [GW-1:0]                   group;
  logic                            lastGroup;

  // Running (best, second) pair carried across scan cycles.
  logic                    bestValid, secValid;
  logic [dataWidth-1:0]    bestVal, secVal;
  logic [addressWidth-1:0] bestIdx, secIdx;

  function automatic logic greater(input logic [dataWidth-1:0] a,
                                   input logic [dataWidth-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    else             return a > b;
  endfunction

  // Zero-pad the capture so the last partial group can be sliced uniformly;
  // padded lanes are masked by index below and never win.
  logic [PW-1:0] padded;
  logic [GV-1:0] groupVec [NG];
  logic [GV-1:0] curGroup;

  assign padded = PW'(capture);

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    assign groupVec[gi] = padded[gi*GV +: GV];
  end

  assign curGroup  = groupVec[group];
  assign lastGroup = (group == GW'(NG - 1));

  // Merge chain: each lane folds one candidate into the pair from the
  // previous lane, starting from the registered running pair.
  for (genvar li = 0; li < LANES; li++) begin : g_lane
    logic                    inBV, inSV, outBV, outSV;
    logic [dataWidth-1:0]    inBVal, inSVal, outBVal, outSVal, val;
    logic [addressWidth-1:0] inBIdx, inSIdx, outBIdx, outSIdx;
    logic [IW-1:0]           idxWide;
    logic                    live, takeBest, takeSec;

    if (li == 0) begin : g_first
      assign inBV   = bestValid;
      assign inBVal = bestVal;
      assign inBIdx = bestIdx;
      assign inSV   = secValid;
      assign inSVal = secVal;
      assign inSIdx = secIdx;
    end else begin : g_next
      assign inBV   = g_lane[li-1].outBV;
      assign inBVal = g_lane[li-1].outBVal;
      assign inBIdx = g_lane[li-1].outBIdx;
      assign inSV   = g_lane[li-1].outSV;
      assign inSVal = g_lane[li-1].outSVal;
      assign inSIdx = g_lane[li-1].outSIdx;
    end

    assign val      = curGroup[li*dataWidth +: dataWidth];
    assign idxWide  = IW'(group) * IW'(LANES) + IW'(li);
    assign live     = idxWide < IW'(numOutputs);
    assign takeBest = live && (!inBV || greater(val, inBVal));
    assign takeSec  = live && !takeBest && (!inSV || greater(val, inSVal));

    // A displaced best drops into second place.
    assign outBV   = inBV | live;
    assign outBVal = takeBest ? val : inBVal;
    assign outBIdx = takeBest ? addressWidth'(idxWide) : inBIdx;
    assign outSV   = takeBest ? inBV   : (takeSec | inSV);
    assign outSVal = takeBest ? inBVal : (takeSec ? val : inSVal);
    assign outSIdx = takeBest ? inBIdx : (takeSec ? addressWidth'(idxWide) : inSIdx);
  end

  logic                    finBV, finSV;
  logic [dataWidth-1:0]    finBVal, finSVal;
  logic [addressWidth-1:0] finBIdx, finSIdx;

  assign finBV   = g_lane[LANES-1].outBV;
  assign finBVal = g_lane[LANES-1].outBVal;
  assign finBIdx = g_lane[LANES-1].outBIdx;
  assign finSV   = g_lane[LANES-1].outSV;
  assign finSVal = g_lane[LANES-1].outSVal;
  assign finSIdx = g_lane[LANES-1].outSIdx;

`ifdef TOPK_MARGIN_EN
  logic [dataWidth:0] extBest, extSec, finMargin;
  assign extBest   = (SIGNED != 0) ? {finBVal[dataWidth-1], finBVal} : {1'b0, finBVal};
  assign extSec    = (SIGNED != 0) ? {finSVal[dataWidth-1], finSVal} : {1'b0, finSVal};
  assign finMargin = extBest - extSec;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      group       <= '0;
      capture     <= '0;
      bestValid   <= 1'b0;
      secValid    <= 1'b0;
      bestVal     <= '0;
      secVal      <= '0;
      bestIdx     <= '0;
      secIdx      <= '0;
      maxIndex    <= '0;
      maxValue    <= '0;
      secondIndex <= '0;
      secondValue <= '0;
`ifdef TOPK_MARGIN_EN
      margin      <= '0;
`endif
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          if (start) begin
            capture   <= dataIn;
            bestValid <= 1'b0;
            secValid  <= 1'b0;
            group     <= '0;
          end
        end
        SCAN: begin
          bestValid <= finBV;
          bestVal   <= finBVal;
          bestIdx   <= finBIdx;
          secValid  <= finSV;
          secVal    <= finSVal;
          secIdx    <= finSIdx;
          if (lastGroup) begin
            maxIndex    <= finBIdx;
            maxValue    <= finBVal;
            secondIndex <= finSIdx;
            secondValue <= finSVal;
`ifdef TOPK_MARGIN_EN
            margin      <= finMargin;
`endif
          end else begin
            group <= group + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nextState  = state;
    startReady = 1'b0;
    busy       = 1'b0;
    outValid   = 1'b0;
    case (state)
      IDLE: begin
        startReady = 1'b1;
        if (start) nextState = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (lastGroup) nextState = DONE;
      end
      DONE: begin
        outValid = 1'b1;
        if (outReady) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_topk_argmax.sv
`timescale 1ns/1ps
// Bench for topk_argmax: three configurations (unsigned LANES=2, signed
// LANES=3, unsigned LANES=1) driven with directed and random vectors and
// checked against a plain sorting-style reference model.
module tb_topk_argmax;

  localparam int NO = 10;
  localparam int DW = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nCmp  = 0;
  int nBad  = 0;
  int nDone = 0;

  function automatic int lanesOf(input int k);
    case (k)
      0:       return 2;
      1:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int signedOf(input int k);
    return (k == 1) ? 1 : 0;
  endfunction

  function automatic logic [7:0] dirByte(input int k, input int i);
    int t0[10] = '{3, 9, 1, 7, 9, 0, 2, 8, 4, 5};
    int t1[10] = '{-5, -2, -8, -2, -1, -128, -3, -4, -6, -7};
    case (k)
      0:       return 8'(t0[i]);
      1:       return 8'(t1[i]);
      default: return 8'(9 - i);
    endcase
  endfunction

  // Hand-computed results for the directed vector of each configuration.
  function automatic void dirExpect(input int k, output int mi, output int mv,
                                    output int si, output int sv, output int mg,
                                    output int lat);
    case (k)
      0:       begin mi = 1; mv = 9;   si = 4; sv = 9;   mg = 0; lat = 5;  end
      1:       begin mi = 4; mv = 255; si = 1; sv = 254; mg = 1; lat = 4;  end
      default: begin mi = 0; mv = 9;   si = 1; sv = 8;   mg = 1; lat = 10; end
    endcase
  endfunction

  task automatic check(input int k, input string name, input int act, input int exp);
    nCmp++;
    if (act != exp) begin
      nBad++;
      $display("FAIL cfg%0d %s: got %0d expected %0d", k, name, act, exp);
    end
  endtask

  // Reference: first maximum by index, then first maximum among the rest.
  function automatic void model(input logic [NO*DW-1:0] v, input int sgn,
                                output int mi, output int mv, output int si,
                                output int sv, output int mg);
    int s[NO];
    logic [7:0] b;
    for (int i = 0; i < NO; i++) begin
      b = v[i*DW +: DW];
      s[i] = (sgn != 0) ? int'($signed(b)) : int'(b);
    end
    mi = 0;
    for (int i = 1; i < NO; i++) if (s[i] > s[mi]) mi = i;
    si = -1;
    for (int i = 0; i < NO; i++)
      if (i != mi && (si < 0 || s[i] > s[si])) si = i;
    b  = v[mi*DW +: DW]; mv = int'(b);
    b  = v[si*DW +: DW]; sv = int'(b);
    mg = s[mi] - s[si];
  endfunction

  function automatic logic [NO*DW-1:0] randVec(input int tieHeavy);
    logic [NO*DW-1:0] v;
    for (int i = 0; i < NO; i++)
      v[i*DW +: DW] = (tieHeavy != 0) ? 8'(8'h7E + 8'($urandom_range(0, 3))) : 8'($urandom);
    return v;
  endfunction

  for (genvar k = 0; k < 3; k++) begin : cfg
    localparam int L   = lanesOf(k);
    localparam int S   = signedOf(k);
    localparam int NGk = (NO + L - 1) / L;

    logic            rst, start, startReady, busy, outValid, outReady;
    logic [NO*DW-1:0] dataIn;
    logic [AW-1:0]   maxIndex, secondIndex;
    logic [DW-1:0]   maxValue, secondValue;
`ifdef TOPK_MARGIN_EN
    logic [DW:0]     margin;
`endif

    topk_argmax #(
      .dataWidth (DW),
      .numOutputs(NO),
      .LANES     (L),
      .SIGNED    (S)
    ) dut (
      .clk        (clk),
      .reset      (rst),
      .start      (start),
      .startReady (startReady),
      .dataIn     (dataIn),
      .busy       (busy),
      .outValid   (outValid),
      .outReady   (outReady),
      .maxIndex   (maxIndex),
      .maxValue   (maxValue),
      .secondIndex(secondIndex),
      .secondValue(secondValue)
`ifdef TOPK_MARGIN_EN
      ,
      .margin     (margin)
`endif
    );

    // Pending = model result of the accepted vector; held = what the
    // outputs must show now (zero after reset, latest completed scan after).
    int pMi = 0, pMv = 0, pSi = 0, pSv = 0, pMg = 0;
    int hMi = 0, hMv = 0, hSi = 0, hSv = 0, hMg = 0;

    always @(negedge clk) begin
      if (rst) begin
        hMi = 0; hMv = 0; hSi = 0; hSv = 0; hMg = 0;
      end else if (outValid) begin
        hMi = pMi; hMv = pMv; hSi = pSi; hSv = pSv; hMg = pMg;
      end
      check(k, "maxIndex",    int'(maxIndex),    hMi);
      check(k, "maxValue",    int'(maxValue),    hMv);
      check(k, "secondIndex", int'(secondIndex), hSi);
      check(k, "secondValue", int'(secondValue), hSv);
`ifdef TOPK_MARGIN_EN
      check(k, "margin",      int'(margin),      hMg);
`endif
    end

    // Called at posedge+1 with the DUT in IDLE; returns with the DUT in IDLE.
    task automatic runVec(input logic [NO*DW-1:0] v, input int hold, output int lat);
      check(k, "accept.startReady", int'(startReady), 1);
      model(v, S, pMi, pMv, pSi, pSv, pMg);
      dataIn = v;
      start  = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      dataIn = randVec(0);
      lat = 0;
      while (!outValid && lat < 40) begin
        check(k, "scan.busy", int'(busy), 1);
        check(k, "scan.startReady", int'(startReady), 0);
        @(posedge clk); #1;
        lat++;
      end
      check(k, "latency", lat, NGk);
      for (int h = 0; h < hold; h++) begin
        check(k, "done.outValid", int'(outValid), 1);
        check(k, "done.startReady", int'(startReady), 0);
        check(k, "done.busy", int'(busy), 0);
        start  = ((h % 2) == 0);
        dataIn = randVec(0);
        @(posedge clk); #1;
      end
      outReady = 1'b1;
      start    = (hold > 0);
      @(posedge clk); #1;
      outReady = 1'b0;
      start    = 1'b0;
      check(k, "exit.outValid", int'(outValid), 0);
      check(k, "exit.startReady", int'(startReady), 1);
      check(k, "exit.busy", int'(busy), 0);
    endtask

    initial begin
      logic [NO*DW-1:0] v;
      int lat, mi, mv, si, sv, mg, lmi, lmv, lsi, lsv, lmg, llat;
      rst = 1'b1; start = 1'b0; outReady = 1'b0; dataIn = '0;
      repeat (3) @(posedge clk);
      #1;
      check(k, "reset.startReady", int'(startReady), 1);
      check(k, "reset.busy", int'(busy), 0);
      check(k, "reset.outValid", int'(outValid), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed vector with hand-computed expectations.
      for (int i = 0; i < NO; i++) v[i*DW +: DW] = dirByte(k, i);
      dirExpect(k, lmi, lmv, lsi, lsv, lmg, llat);
      model(v, S, mi, mv, si, sv, mg);
      check(k, "model.maxIndex", mi, lmi);
      check(k, "model.secondIndex", si, lsi);
      check(k, "model.margin", mg, lmg);
      runVec(v, 0, lat);
      check(k, "dir.latency", lat, llat);
      check(k, "dir.maxIndex", int'(maxIndex), lmi);
      check(k, "dir.maxValue", int'(maxValue), lmv);
      check(k, "dir.secondIndex", int'(secondIndex), lsi);
      check(k, "dir.secondValue", int'(secondValue), lsv);
`ifdef TOPK_MARGIN_EN
      check(k, "dir.margin", int'(margin), lmg);
`endif

      // All scores equal.
      for (int i = 0; i < NO; i++) v[i*DW +: DW] = 8'h40;
      runVec(v, 0, lat);
      check(k, "eq.maxIndex", int'(maxIndex), 0);
      check(k, "eq.secondIndex", int'(secondIndex), 1);
      check(k, "eq.maxValue", int'(maxValue), 64);
      check(k, "eq.secondValue", int'(secondValue), 64);
`ifdef TOPK_MARGIN_EN
      check(k, "eq.margin", int'(margin), 0);
`endif

      // Back-pressure in DONE with start pulsing, then immediate re-accept.
      runVec(randVec(0), 6, lat);
      runVec(randVec(1), 0, lat);

      // Reset during the third scan cycle.
      v = randVec(0);
      check(k, "abort.startReady", int'(startReady), 1);
      dataIn = v;
      start  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check(k, "abort.busy", int'(busy), 0);
      check(k, "abort.outValid", int'(outValid), 0);
      check(k, "abort.startReady", int'(startReady), 1);
      check(k, "abort.maxIndex", int'(maxIndex), 0);
      check(k, "abort.maxValue", int'(maxValue), 0);
      check(k, "abort.secondIndex", int'(secondIndex), 0);
      check(k, "abort.secondValue", int'(secondValue), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      runVec(randVec(0), 0, lat);

      repeat (20) runVec(randVec(int'($urandom_range(0, 1))), int'($urandom_range(0, 2)), lat);
      nDone++;
    end
  end

  initial begin
    for (int t = 0; t < 60000 && nDone < 3; t++) @(posedge clk);
    check(-1, "completion", nDone, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
